// File: rtl/range_pkg.sv
// Shared definitions for the range-finder front end.
//   DefaultWidth / DefaultDepth : sample width and frame depth, shared with the range finder.
//   feeder_state_t              : range_burst_feeder FSM states.
package range_pkg;

  localparam int unsigned DefaultWidth = 10;
  localparam int unsigned DefaultDepth = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DROP  = 2'd2,
    BURST = 2'd3
  } feeder_state_t;

endpackage

// File: rtl/range_burst_feeder_if.sv
// Sample-stream interface between the input pins, the feeder and the range finder.
//   in_data/in_valid/in_last/in_ready : upstream valid/ready sample stream.
//   out_data/out_go/out_finish        : burst towards the range finder.
// Modports: master = upstream source and burst sink, slave = the feeder.
interface range_burst_feeder_if
  import range_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_go;
  logic             out_finish;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_data,
    input  out_go,
    input  out_finish
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_data,
    output out_go,
    output out_finish
  );

endinterface

// File: rtl/range_sample_buf.sv
// Frame buffer: DEPTH x WIDTH register array.
//   clk_i   : clock
//   clr_i   : synchronous clear of every entry (has priority over the write)
//   we_i    : write enable, waddr_i / wdata_i : write address and data
//   raddr_i : combinational read address, rdata_o : read data
module range_sample_buf #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     clr_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/range_burst_feeder.sv
// Upstream feeder for the range finder. Collects a frame of up to DEPTH samples over a
// valid/ready stream, then replays it as a gap-free burst: out_go with the first sample,
// one sample per cycle, out_finish on the cycle after the last. Oversized frames are
// discarded and flagged with the sticky overflow_err.
//   clock, reset  : single clock, synchronous active-high reset
//   bus (slave)   : in_* sample stream and out_* burst (see range_burst_feeder_if)
//   busy          : a frame is being collected, dropped or replayed
//   overflow_err  : sticky, a frame exceeded DEPTH; cleared by reset only
//   frame_count   : only with RANGE_FEEDER_FRAME_COUNT_EN; completed bursts, wraps at 255
module range_burst_feeder
  import range_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned DEPTH = DefaultDepth
) (
  input  logic                 clock,
  input  logic                 reset,
  range_burst_feeder_if.slave  bus,
  output logic                 busy,
  output logic                 overflow_err
`ifdef RANGE_FEEDER_FRAME_COUNT_EN
  ,
  output logic [7:0]           frame_count
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  // One extra bit so a full frame of DEPTH samples is representable.
  localparam int unsigned CW = AW + 1;

  feeder_state_t    state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    rptr_q, rptr_d;
  logic [CW-1:0]    rnext;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_go_q, out_go_d;
  logic             out_fin_q, out_fin_d;
  logic             in_ready_q, in_ready_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  logic             buf_clr;
  logic             buf_we;
  logic [AW-1:0]    buf_waddr;
  logic [AW-1:0]    buf_raddr;
  logic [WIDTH-1:0] buf_rdata;

  range_sample_buf #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk_i   (clock),
    .clr_i   (buf_clr),
    .we_i    (buf_we),
    .waddr_i (buf_waddr),
    .wdata_i (bus.in_data),
    .raddr_i (buf_raddr),
    .rdata_o (buf_rdata)
  );

  assign accept = bus.in_valid & in_ready_q;
  assign rnext  = rptr_q + CW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rptr_d     = rptr_q;
    out_data_d = '0;
    out_go_d   = 1'b0;
    out_fin_d  = 1'b0;
    ovf_d      = ovf_q;
    buf_clr    = reset;
    buf_we     = 1'b0;
    buf_waddr  = count_q[AW-1:0];
    buf_raddr  = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          buf_we    = 1'b1;
          buf_waddr = '0;
          count_d   = CW'(1);
          if (bus.in_last) begin
            // Single-sample frame: sample 0 is not in the buffer yet, present it directly.
            state_d    = BURST;
            rptr_d     = '0;
            out_go_d   = 1'b1;
            out_data_d = bus.in_data;
          end else begin
            state_d = FILL;
          end
        end
      end

      FILL: begin
        if (accept) begin
          if (count_q == CW'(DEPTH)) begin
            // Sample DEPTH+1: discard the frame, finish it in DROP unless it ends here.
            ovf_d   = 1'b1;
            buf_clr = 1'b1;
            count_d = '0;
            state_d = bus.in_last ? IDLE : DROP;
          end else begin
            buf_we  = 1'b1;
            count_d = count_q + CW'(1);
            if (bus.in_last) begin
              state_d    = BURST;
              rptr_d     = '0;
              out_go_d   = 1'b1;
              out_data_d = buf_rdata;
            end
          end
        end
      end

      DROP: begin
        if (accept && bus.in_last) begin
          state_d = IDLE;
        end
      end

      BURST: begin
        // rptr_q is the sample on the outputs now; prefetch the next one.
        buf_raddr = rnext[AW-1:0];
        if (rnext < count_q) begin
          out_data_d = buf_rdata;
          rptr_d     = rnext;
        end else if (rnext == count_q) begin
          out_fin_d = 1'b1;
          rptr_d    = rnext;
        end else begin
          state_d = IDLE;
          count_d = '0;
          rptr_d  = '0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d != BURST);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      rptr_q     <= '0;
      out_data_q <= '0;
      out_go_q   <= 1'b0;
      out_fin_q  <= 1'b0;
      in_ready_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rptr_q     <= rptr_d;
      out_data_q <= out_data_d;
      out_go_q   <= out_go_d;
      out_fin_q  <= out_fin_d;
      in_ready_q <= in_ready_d;
      ovf_q      <= ovf_d;
    end
  end

`ifdef RANGE_FEEDER_FRAME_COUNT_EN
  logic [7:0] frame_count_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      frame_count_q <= '0;
    end else if (out_fin_d) begin
      frame_count_q <= frame_count_q + 8'd1;
    end
  end

  assign frame_count = frame_count_q;
`endif

  assign bus.in_ready   = in_ready_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_go     = out_go_q;
  assign bus.out_finish = out_fin_q;
  assign busy           = (state_q != IDLE);
  assign overflow_err   = ovf_q;

endmodule

// File: doc/range_burst_feeder.md
Name: range_burst_feeder

Overview:
- Upstream feeder for the range-finder stage; sits between the chip's input pins and the range finder's data_in/go/finish inputs.
- Accepts one sample per valid/ready handshake and buffers a whole frame of up to DEPTH samples.
- Once the frame is complete, replays it as a gap-free burst: go on the first sample, one sample per cycle, finish after the last.
- Flags and discards frames that exceed DEPTH.

Parameters:
- WIDTH, 10, sample width in bits; must match the range finder's data width.
- DEPTH, 8, maximum samples per frame; power of two, ≥2.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  incoming sample.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  qualified by in_valid; this sample ends the frame.
- in_ready  out  1  feeder accepts a sample this cycle.
- out_data  out  WIDTH  sample to the range finder's data_in.
- out_go  out  1  one-cycle pulse with the first sample of a burst.
- out_finish  out  1  one-cycle pulse on the cycle after the last burst sample.
- busy  out  1  frame is being collected or replayed.
- overflow_err  out  1  sticky; a frame exceeded DEPTH.

Behaviour:
- Reset: all outputs 0 (in_ready included), buffer count 0, state IDLE, overflow_err cleared. Reset mid-burst aborts immediately; no finish is emitted.
- Handshake: a sample is accepted when in_valid && in_ready. in_last is ignored unless in_valid is high. Every frame therefore holds at least one sample.
- States:
  - IDLE: in_ready=1, busy=0. An accept stores the sample at index 0 and moves to FILL, or to BURST if in_last is set.
  - FILL: in_ready=1, busy=1. Each accept stores the sample at index count and increments count. An accept with in_last moves to BURST.
  - FILL overflow: an accept that would be sample DEPTH+1 without in_last sets overflow_err and moves to DROP. The sample is discarded and the buffer cleared.
  - DROP: in_ready=1, busy=1. All samples are accepted and discarded until an accepted in_last, then IDLE. If that in_last arrives on the overflowing sample itself, go straight to IDLE.
  - BURST: in_ready=0, busy=1.
    - Burst cycle 0: out_go=1, out_data=sample[0].
    - Burst cycle k (1..N-1): out_data=sample[k], out_go=0.
    - Burst cycle N: out_finish=1, out_data=0.
    - Then to IDLE.
- Latency: out_go asserts exactly one cycle after the cycle that accepted in_last.
- Timing: out_data, out_go and out_finish are registered. out_data is 0 whenever no burst sample is being presented.
- Timing: in_ready is a registered function of state only; it does not combinationally depend on in_valid.
- Full buffer: a frame of exactly DEPTH samples is legal (in_last on sample DEPTH). Count width is $clog2(DEPTH)+1 so DEPTH is representable without wrap.
- The read pointer wraps never within a burst; it is reset to 0 at burst start.
- Back-to-back frames: the sample offered on the cycle BURST returns to IDLE is accepted (in_ready=1 in IDLE).
- overflow_err clears only on reset.

Optional Feature:
- Macro: RANGE_FEEDER_FRAME_COUNT_EN.
- When defined: adds output frame_count [7:0].
  - Increments on each out_finish and wraps 255→0.
  - Reset to 0.
  - Dropped frames are not counted.
- When undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package range_pkg:
  - typedef enum {IDLE, FILL, DROP, BURST} feeder_state_t.
  - Default WIDTH and DEPTH localparams, shared with the range finder instance.
- One natural sub-module: range_sample_buf. A DEPTH×WIDTH register array with write port (we, waddr, wdata), combinational read (raddr→rdata) and synchronous clear.
- The FSM and counters stay in range_burst_feeder.

Test Plan:
- Frame of 3: accept 5, 900, 17 (last on 17).
  - Next cycle: out_go=1, out_data=5.
  - Then 900, then 17.
  - Then out_finish=1, out_data=0; IDLE after.
- Single-sample frame: accept 42 with in_last → out_go=1/out_data=42, next cycle out_finish=1. Total burst length 2 cycles.
- Full frame: 8 samples 0..7, last on 7 → burst of 8 data cycles then finish; overflow_err stays 0.
- Overflow: 9 samples, no last, then 2 more samples with last on the 11th → overflow_err=1 from the 9th accept, no out_go ever. Then a new frame of 1 (value 3) bursts correctly.
- Reset mid-burst: reset asserted on burst cycle 2 of a 5-sample frame → next cycle all outputs 0, in_ready=0; in_ready=1 the cycle after reset deasserts; no out_finish seen.
- Throttled input: in_valid toggling 1/0 with in_last on the 4th accepted sample → burst still contiguous (4 data cycles + finish). With RANGE_FEEDER_FRAME_COUNT_EN, frame_count=1 after finish.
